lzrw1_compressor_core: RTL and testbench

- Byte-stream LZRW1-style compressor.
- Produces the 16-bit item stream plus one control bit per item that decompressor_top consumes.
- Greedy single-candidate match: a 3-byte hash selects one prior position; byte-serial compare; emits a literal or a copy item.
- Sits between the byte source (host/FIFO) and the compressed-item sink (file writer or decompressor input).

---
 rtl/lzrw1_pkg.sv | 38 +++
 rtl/lzrw1_hash_table.sv | 37 +++
 rtl/lzrw1_compressor_core.sv | 198 +++++++++++++++++++
 tb/tb_lzrw1_compressor_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lzrw1_pkg.sv
// LZRW1 item format, FSM state encoding and 3-byte match hash.
// Shared by the compressor core and the decompressor.
package lzrw1_pkg;

    localparam int MIN_MATCH = 3;
    localparam int MAX_MATCH = 18;
    localparam int OFFSET_W  = 12;
    localparam int LEN_W     = 4;
    localparam int ITEM_W    = OFFSET_W + LEN_W;

    typedef enum logic [2:0] {FILL, HASH, MATCH, EMIT, DONE} state_t;

    // b0 ^ rotl8(b1,3) ^ rotl8(b2,6); callers keep the low HASH_BITS bits
    function automatic logic [7:0] hash3(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2);
        return b0 ^ {b1[4:0], b1[7:5]} ^ {b2[1:0], b2[7:2]};
    endfunction

    function automatic logic [ITEM_W-1:0] encode_literal(input logic [7:0] b);
        return {8'h00, b};
    endfunction

    function automatic logic [ITEM_W-1:0] encode_copy(input logic [OFFSET_W-1:0] offset,
                                                      input logic [4:0] len);
        logic [4:0] len_m3;
        len_m3 = len - 5'(MIN_MATCH);
        return {offset, len_m3[LEN_W-1:0]};
    endfunction

    function automatic logic [OFFSET_W-1:0] decode_offset(input logic [ITEM_W-1:0] item);
        return item[ITEM_W-1:LEN_W];
    endfunction

    function automatic logic [4:0] decode_length(input logic [ITEM_W-1:0] item);
        return 5'(item[LEN_W-1:0]) + 5'(MIN_MATCH);
    endfunction

endpackage

// File: rtl/lzrw1_hash_table.sv
// Hash -> last item-start position table: combinational read, synchronous write,
// valid bits in flops so the whole table can be invalidated in one cycle.
module lzrw1_hash_table #(
    parameter int HASH_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [HASH_BITS-1:0] addr,
    output logic                 entry_valid,
    output logic [15:0]          entry_pos,
    input  logic                 write_en,
    input  logic [15:0]          write_pos,
    input  logic                 clear
);
    localparam int ENTRIES = 1 << HASH_BITS;

    logic [15:0]        pos_mem [ENTRIES];
    logic [ENTRIES-1:0] valid;

    assign entry_valid = valid[addr];
    assign entry_pos   = pos_mem[addr];

    always_ff @(posedge clock) begin
        if (write_en)
            pos_mem[addr] <= write_pos;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            valid <= '0;
        else if (clear)
            valid <= '0;
        else if (write_en)
            valid[addr] <= 1'b1;
    end

endmodule

// File: rtl/lzrw1_compressor_core.sv
// Greedy single-candidate LZRW1 compressor: buffers up to MAX_MATCH lookahead bytes,
// hashes 3 bytes to one prior position, compares byte-serially, emits a literal or copy.
module lzrw1_compressor_core #(
    parameter int HISTORY_SIZE = 256,
    parameter int HASH_BITS    = 8,
    parameter int MAX_MATCH    = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    input  logic        byte_in_last,
    output logic        byte_in_ready,
    output logic [15:0] data_out,
    output logic        control_word_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done
);
    import lzrw1_pkg::*;

    localparam int RING_SIZE = 2 * HISTORY_SIZE;
    localparam int RING_W    = $clog2(RING_SIZE);

    state_t state, state_nxt;

    logic [15:0] pos;
    logic [15:0] cand;
    logic [4:0]  la;
    logic [4:0]  k;
    logic [4:0]  adv;
    logic        last_seen;
    logic [7:0]  ring [RING_SIZE];

    logic                 take;
    logic [7:0]           b0, b1, b2;
    logic [7:0]           src_byte, dst_byte;
    logic [7:0]           h8;
    logic [HASH_BITS-1:0] h;
    logic                 ht_valid;
    logic [15:0]          ht_pos;
    logic [15:0]          offset;
    logic                 cand_ok;
    logic                 match_eq;
    logic [4:0]           match_len;

    logic ht_we, ht_clear, start_match, step_match, load_lit, load_copy, item_done;

    assign byte_in_ready = !reset && (state == FILL) && (la < 5'(MAX_MATCH)) && !last_seen;
    assign take          = byte_in_valid && byte_in_ready;
    assign done          = (state == DONE);

    assign b0       = ring[RING_W'(pos)];
    assign b1       = ring[RING_W'(pos + 16'd1)];
    assign b2       = ring[RING_W'(pos + 16'd2)];
    assign src_byte = ring[RING_W'(cand + 16'(k))];
    assign dst_byte = ring[RING_W'(pos + 16'(k))];

    assign h8 = hash3(b0, b1, b2);
    assign h  = h8[HASH_BITS-1:0];

    // Offset wraps mod 2^16, so a stale entry ahead of pos shows up as a huge offset
    assign offset  = pos - ht_pos;
    assign cand_ok = ht_valid && (offset != 16'd0) && (offset < 16'(HISTORY_SIZE));

    assign match_eq  = (src_byte == dst_byte);
    assign match_len = match_eq ? (k + 5'd1) : k;

    lzrw1_hash_table #(
        .HASH_BITS (HASH_BITS)
    ) u_hash_table (
        .clock       (clock),
        .reset       (reset),
        .addr        (h),
        .entry_valid (ht_valid),
        .entry_pos   (ht_pos),
        .write_en    (ht_we),
        .write_pos   (pos),
        .clear       (ht_clear)
    );

    always_ff @(posedge clock) begin
        if (take)
            ring[RING_W'(pos + 16'(la))] <= byte_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ht_we       = 1'b0;
        ht_clear    = 1'b0;
        start_match = 1'b0;
        step_match  = 1'b0;
        load_lit    = 1'b0;
        load_copy   = 1'b0;
        item_done   = 1'b0;
        case (state)
            FILL: begin
                if (last_seen && la == 5'd0)
                    state_nxt = DONE;
                else if (la == 5'(MAX_MATCH) || (last_seen && la != 5'd0))
                    state_nxt = HASH;
            end
            HASH: begin
                if (la >= 5'(MIN_MATCH)) begin
                    ht_we = 1'b1;
                    if (cand_ok) begin
                        start_match = 1'b1;
                        state_nxt   = MATCH;
                    end else begin
                        load_lit  = 1'b1;
                        state_nxt = EMIT;
                    end
                end else begin
                    load_lit  = 1'b1;
                    state_nxt = EMIT;
                end
            end
            MATCH: begin
                // la never exceeds MAX_MATCH, so it alone bounds the compare
                if (match_eq && (k + 5'd1 != la)) begin
                    step_match = 1'b1;
                end else begin
                    state_nxt = EMIT;
                    if (match_len >= 5'(MIN_MATCH))
                        load_copy = 1'b1;
                    else
                        load_lit = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    item_done = 1'b1;
                    state_nxt = FILL;
                end
            end
            DONE: begin
                ht_clear  = 1'b1;
                state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos              <= '0;
            la               <= '0;
            last_seen        <= 1'b0;
            cand             <= '0;
            k                <= '0;
            adv              <= '0;
            data_out         <= '0;
            control_word_out <= 1'b0;
            out_valid        <= 1'b0;
        end else begin
            if (take) begin
                la <= la + 5'd1;
                if (byte_in_last)
                    last_seen <= 1'b1;
            end
            if (start_match) begin
                cand <= ht_pos;
                k    <= '0;
            end
            if (step_match)
                k <= k + 5'd1;
            if (load_lit) begin
                data_out         <= encode_literal(b0);
                control_word_out <= 1'b0;
                adv              <= 5'd1;
                out_valid        <= 1'b1;
            end
            if (load_copy) begin
                data_out         <= encode_copy(OFFSET_W'(pos - cand), match_len);
                control_word_out <= 1'b1;
                adv              <= match_len;
                out_valid        <= 1'b1;
            end
            if (item_done) begin
                pos       <= pos + 16'(adv);
                la        <= la - adv;
                out_valid <= 1'b0;
            end
            if (state == DONE) begin
                pos       <= '0;
                last_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lzrw1_compressor_core.sv
// Directed bench for lzrw1_compressor_core: vector table plus far-offset and mid-match reset sequences.
module tb_lzrw1_compressor_core;

    logic        clock;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_in_valid;
    logic        byte_in_last;
    logic        byte_in_ready;
    logic [15:0] data_out;
    logic        control_word_out;
    logic        out_valid;
    logic        out_ready;
    logic        done;

    lzrw1_compressor_core #(
        .HISTORY_SIZE (256),
        .HASH_BITS    (8),
        .MAX_MATCH    (18)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .byte_in          (byte_in),
        .byte_in_valid    (byte_in_valid),
        .byte_in_last     (byte_in_last),
        .byte_in_ready    (byte_in_ready),
        .data_out         (data_out),
        .control_word_out (control_word_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .done             (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0][7:0] text;
        logic [5:0]       len;
        logic [2:0]       n_items;
        logic [3:0][16:0] items;   // {control, data}
    } vec_t;

    vec_t        vecs [5];
    logic [7:0]  src [$];
    logic [16:0] got [$];
    int          src_idx;
    int          dones;
    logic        held_pending;
    logic [16:0] held;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string s, input int n, input logic [16:0] e0,
                                input logic [16:0] e1, input logic [16:0] e2,
                                input logic [16:0] e3);
        vec_t v;
        v = '0;
        v.len = 6'(s.len());
        for (int i = 0; i < s.len(); i++) v.text[i] = s[i];
        v.n_items  = 3'(n);
        v.items[0] = e0;
        v.items[1] = e1;
        v.items[2] = e2;
        v.items[3] = e3;
        return v;
    endfunction

    // Independent LZRW1 decoder: expands the captured items and compares with the source
    function automatic int decode_errors();
        logic [7:0] outq [$];
        int errs;
        errs = 0;
        foreach (got[i]) begin
            if (!got[i][16]) begin
                if (got[i][15:8] != 8'h00) errs++;
                outq.push_back(got[i][7:0]);
            end else begin
                int off;
                int len;
                off = int'(got[i][15:4]);
                len = int'(got[i][3:0]) + 3;
                if (off == 0 || off >= 256 || off > outq.size())
                    errs++;
                else
                    for (int j = 0; j < len; j++) outq.push_back(outq[outq.size() - off]);
            end
        end
        if (outq.size() != src.size())
            errs++;
        else
            foreach (src[i]) if (outq[i] !== src[i]) errs++;
        return errs;
    endfunction

    // One clock of stimulus/observation, everything on the falling edge
    task automatic cycle_io(input int ready_pct);
        @(negedge clock);
        if (held_pending)
            check("hold", 32'({out_valid, control_word_out, data_out}), 32'({1'b1, held}));
        byte_in_valid = (src_idx < src.size());
        byte_in       = byte_in_valid ? src[src_idx] : 8'h00;
        byte_in_last  = byte_in_valid && (src_idx == src.size() - 1);
        out_ready     = (int'($urandom_range(99)) < ready_pct);
        #1;
        if (byte_in_valid && byte_in_ready) src_idx++;
        if (out_valid && out_ready) got.push_back({control_word_out, data_out});
        held_pending = out_valid && !out_ready;
        held         = {control_word_out, data_out};
        if (done) dones++;
    endtask

    task automatic run_stream(input string tag, input int ready_pct, input int budget);
        int tail;
        int cyc;
        tail = 0;
        cyc  = 0;
        got.delete();
        dones        = 0;
        src_idx      = 0;
        held_pending = 1'b0;
        while (cyc < budget && tail < 4) begin
            cycle_io(ready_pct);
            cyc++;
            if (dones > 0) tail++;
        end
        check({tag, " done pulses"}, 32'(dones), 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        src.delete();
        for (int i = 0; i < int'(v.len); i++) src.push_back(v.text[i]);
        run_stream(tag, 100, 1000);
        check({tag, " count"}, 32'(got.size()), 32'(v.n_items));
        for (int i = 0; i < int'(v.n_items); i++)
            check($sformatf("%s item%0d", tag, i),
                  (i < got.size()) ? 32'(got[i]) : 32'hdead_beef, 32'(v.items[i]));
        check({tag, " decode"}, 32'(decode_errors()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s30;
        string s;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        byte_in = 8'h00;
        byte_in_valid = 1'b0;
        byte_in_last = 1'b0;
        out_ready = 1'b0;
        src_idx = 0;
        dones = 0;
        held_pending = 1'b0;
        held = '0;

        s30 = "";
        for (int i = 0; i < 30; i++) s30 = {s30, "x"};
        vecs[0] = mk("abcabcabc", 4, 17'h00061, 17'h00062, 17'h00063, 17'h10033);
        vecs[1] = mk("aaaa",      2, 17'h00061, 17'h10010, 17'h0,     17'h0);
        vecs[2] = mk(s30,         3, 17'h00078, 17'h1001F, 17'h10128, 17'h0);
        vecs[3] = mk("hi",        2, 17'h00068, 17'h00069, 17'h0,     17'h0);
        vecs[4] = mk("hi",        2, 17'h00068, 17'h00069, 17'h0,     17'h0);

        repeat (3) @(negedge clock);
        check("reset data_out",    32'(data_out),         32'd0);
        check("reset control",     32'(control_word_out), 32'd0);
        check("reset out_valid",   32'(out_valid),        32'd0);
        check("reset done",        32'(done),             32'd0);
        check("reset ready",       32'(byte_in_ready),    32'd0);
        reset = 1'b0;
        #1;
        check("post-reset ready",  32'(byte_in_ready),    32'd1);

        for (int v = 0; v < 5; v++) apply_vec(vecs[v], $sformatf("vec%0d", v));

        // Repeat of "abc" 256 bytes later is out of window; random backpressure throughout
        src.delete();
        s = "abc";
        for (int i = 0; i < 3; i++) src.push_back(s[i]);
        for (int i = 0; i < 253; i++) src.push_back(8'hFF);
        for (int i = 0; i < 3; i++) src.push_back(s[i]);
        run_stream("far", 50, 4000);
        for (int i = 0; i < 3; i++)
            check($sformatf("far tail%0d", i),
                  (got.size() >= 3) ? 32'(got[got.size() - 3 + i]) : 32'hdead_beef,
                  32'h61 + 32'(i));
        check("far decode", 32'(decode_errors()), 32'd0);

        // Reset while the "abcabc" copy is being compared
        src.delete();
        s = "abcabcabc";
        for (int i = 0; i < 9; i++) src.push_back(s[i]);
        got.delete();
        dones = 0;
        src_idx = 0;
        held_pending = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (got.size() < 3 && cyc < 500) begin
                cycle_io(100);
                cyc++;
            end
        end
        check("mid items before reset", 32'(got.size()), 32'd3);
        repeat (4) cycle_io(100);
        check("mid no copy yet", 32'(got.size()), 32'd3);
        byte_in_valid = 1'b0;
        out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("mid reset data_out",  32'(data_out),         32'd0);
        check("mid reset control",   32'(control_word_out), 32'd0);
        check("mid reset out_valid", 32'(out_valid),        32'd0);
        check("mid reset done",      32'(done),             32'd0);
        check("mid reset ready",     32'(byte_in_ready),    32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        src.delete();
        got.delete();
        dones = 0;
        src_idx = 0;
        held_pending = 1'b0;
        repeat (6) cycle_io(100);
        check("mid no done", 32'(dones), 32'd0);
        check("mid no items", 32'(got.size()), 32'd0);
        apply_vec(vecs[0], "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
